// File: rtl/datapath_seq_ctrl.sv
// rtl/datapath_seq_ctrl.sv - Moore sequencer for the 16-bit register-file/ALU datapath
module datapath_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [3:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WR_IMM = 3'd2,
        ST_GET_A  = 3'd3,
        ST_GET_B  = 3'd4,
        ST_EXEC   = 3'd5,
        ST_WR_REG = 3'd6
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] opc_q;
    logic [1:0] op_q;

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_mvn;
    logic is_alu3;
    logic is_cmp;
    logic is_illegal;
    logic accept;

    // Decodes run off the latched fields so mid-instruction input changes are ignored
    assign is_mov_imm = (opc_q == 3'b110) && (op_q == 2'b10);
    assign is_mov_reg = (opc_q == 3'b110) && (op_q == 2'b00);
    assign is_mvn     = (opc_q == 3'b101) && (op_q == 2'b11);
    assign is_alu3    = (opc_q == 3'b101) && (op_q != 2'b11);
    assign is_cmp     = (opc_q == 3'b101) && (op_q == 2'b01);
    assign is_illegal = !(is_mov_imm || is_mov_reg || is_mvn || is_alu3);
    assign accept     = (state == ST_WAIT) && s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_WAIT;
            opc_q <= 3'b000;
            op_q  <= 2'b00;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                opc_q <= opcode;
                op_q  <= op;
                err   <= 1'b0;
            end else if ((state == ST_DECODE) && is_illegal) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT:   state_nxt = s ? ST_DECODE : ST_WAIT;
            ST_DECODE: begin
                if (is_mov_imm)
                    state_nxt = ST_WR_IMM;
                else if (is_mov_reg || is_mvn)
                    state_nxt = ST_GET_B;
                else if (is_alu3)
                    state_nxt = ST_GET_A;
                else
                    state_nxt = ST_WAIT;
            end
            ST_WR_IMM: state_nxt = ST_WAIT;
            ST_GET_A:  state_nxt = ST_GET_B;
            ST_GET_B:  state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = is_cmp ? ST_WAIT : ST_WR_REG;
            ST_WR_REG: state_nxt = ST_WAIT;
            default:   state_nxt = ST_WAIT;
        endcase
    end

    always_comb begin
        w     = 1'b0;
        nsel  = 3'b000;
        vsel  = 4'b0000;
        loada = 1'b0;
        loadb = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        write = 1'b0;
        case (state)
            ST_WAIT:   w = 1'b1;
            ST_WR_IMM: begin
                nsel  = 3'b100;
                vsel  = 4'b0100;
                write = 1'b1;
            end
            ST_GET_A: begin
                nsel  = 3'b100;
                loada = 1'b1;
            end
            ST_GET_B: begin
                nsel  = 3'b001;
                loadb = 1'b1;
            end
            ST_EXEC: begin
                // MOV-reg and MVN pass B through the ALU with A forced to zero
                asel  = is_mov_reg || is_mvn;
                loads = is_cmp;
                loadc = !is_cmp;
            end
            ST_WR_REG: begin
                nsel  = 3'b010;
                vsel  = 4'b0001;
                write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// tb/tb_datapath_seq_ctrl.sv - table-driven scoreboard bench for datapath_seq_ctrl
module tb_datapath_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic       w;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       loada, loadb, asel, bsel, loadc, loads, write, err;

    datapath_seq_ctrl dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
        .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
        .write(write), .err(err)
    );

    always #5 clk = ~clk;

    // {w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, err}
    localparam logic [15:0] V_WAIT  = 16'b1_000_0000_0000000_0;
    localparam logic [15:0] V_DEC   = 16'b0_000_0000_0000000_0;
    localparam logic [15:0] V_WRIMM = 16'b0_100_0100_0000001_0;
    localparam logic [15:0] V_GETA  = 16'b0_100_0000_1000000_0;
    localparam logic [15:0] V_GETB  = 16'b0_001_0000_0100000_0;
    localparam logic [15:0] V_EXMOV = 16'b0_000_0000_0010100_0;
    localparam logic [15:0] V_EXALU = 16'b0_000_0000_0000100_0;
    localparam logic [15:0] V_EXCMP = 16'b0_000_0000_0000010_0;
    localparam logic [15:0] V_WRREG = 16'b0_010_0001_0000001_0;
    localparam logic [15:0] V_ERR   = 16'b0_000_0000_0000000_1;
    localparam logic [15:0] V_NONE  = 16'h0000;

    typedef struct {
        logic [2:0]        opcode;
        logic [1:0]        op;
        int                n;
        logic [5:0][15:0]  seq;
    } rec_t;

    rec_t        tbl [11];
    logic [15:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cur_id = 0;

    function automatic rec_t mk(input logic [2:0] oc, input logic [1:0] o, input int n,
                                input logic [15:0] s0, input logic [15:0] s1,
                                input logic [15:0] s2, input logic [15:0] s3,
                                input logic [15:0] s4, input logic [15:0] s5);
        rec_t r;
        r.opcode = oc;
        r.op     = o;
        r.n      = n;
        r.seq[0] = s0; r.seq[1] = s1; r.seq[2] = s2;
        r.seq[3] = s3; r.seq[4] = s4; r.seq[5] = s5;
        return r;
    endfunction

    task automatic step();
        logic [15:0] got;
        logic [15:0] exp;
        @(posedge clk);
        #1;
        got = {w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, err};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL id%0d scoreboard-empty got=%b required=entry", cur_id, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_fail++;
                $display("FAIL id%0d outputs got=%b required=%b", cur_id, got, exp);
            end
        end
    endtask

    task automatic run_rec(input rec_t r);
        s      = 1'b1;
        opcode = r.opcode;
        op     = r.op;
        for (int i = 0; i < r.n; i++) exp_q.push_back(r.seq[i]);
        step();
        // Scramble the fields once accepted; the latched copy must be used
        s      = 1'b0;
        opcode = ~r.opcode;
        op     = ~r.op;
        for (int i = 1; i < r.n; i++) step();
    endtask

    initial begin
        tbl[0]  = mk(3'b110, 2'b10, 3, V_DEC, V_WRIMM, V_WAIT, V_NONE, V_NONE, V_NONE);
        tbl[1]  = mk(3'b101, 2'b00, 6, V_DEC, V_GETA, V_GETB, V_EXALU, V_WRREG, V_WAIT);
        tbl[2]  = mk(3'b110, 2'b00, 5, V_DEC, V_GETB, V_EXMOV, V_WRREG, V_WAIT, V_NONE);
        tbl[3]  = mk(3'b101, 2'b01, 5, V_DEC, V_GETA, V_GETB, V_EXCMP, V_WAIT, V_NONE);
        tbl[4]  = mk(3'b111, 2'b00, 2, V_DEC, V_WAIT | V_ERR, V_NONE, V_NONE, V_NONE, V_NONE);
        tbl[5]  = mk(3'b101, 2'b10, 6, V_DEC, V_GETA, V_GETB, V_EXALU, V_WRREG, V_WAIT);
        tbl[6]  = mk(3'b101, 2'b11, 5, V_DEC, V_GETB, V_EXMOV, V_WRREG, V_WAIT, V_NONE);
        tbl[7]  = mk(3'b110, 2'b01, 2, V_DEC, V_WAIT | V_ERR, V_NONE, V_NONE, V_NONE, V_NONE);
        tbl[8]  = mk(3'b000, 2'b00, 2, V_DEC, V_WAIT | V_ERR, V_NONE, V_NONE, V_NONE, V_NONE);
        tbl[9]  = mk(3'b110, 2'b11, 2, V_DEC, V_WAIT | V_ERR, V_NONE, V_NONE, V_NONE, V_NONE);
        tbl[10] = mk(3'b110, 2'b10, 3, V_DEC, V_WRIMM, V_WAIT, V_NONE, V_NONE, V_NONE);

        // Reset for two cycles; s high during reset must be ignored
        cur_id = 100;
        s = 1'b1;
        opcode = 3'b110;
        op = 2'b10;
        exp_q.push_back(V_WAIT);
        exp_q.push_back(V_WAIT);
        step();
        step();
        reset = 1'b0;
        s = 1'b0;

        for (int k = 0; k < 11; k++) begin
            cur_id = k;
            run_rec(tbl[k]);
        end

        // err is sticky through idle WAIT cycles and cleared by reset
        cur_id = 200;
        run_rec(mk(3'b111, 2'b11, 2, V_DEC, V_WAIT | V_ERR, V_NONE, V_NONE, V_NONE, V_NONE));
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(V_WAIT | V_ERR);
            step();
        end
        reset = 1'b1;
        exp_q.push_back(V_WAIT);
        step();
        reset = 1'b0;

        // Reset (with s also high) during GET_B of an ADD aborts before loadc/write
        cur_id = 300;
        s = 1'b1;
        opcode = 3'b101;
        op = 2'b00;
        exp_q.push_back(V_DEC);
        exp_q.push_back(V_GETA);
        exp_q.push_back(V_GETB);
        step();
        s = 1'b0;
        step();
        step();
        reset = 1'b1;
        s = 1'b1;
        exp_q.push_back(V_WAIT);
        exp_q.push_back(V_WAIT);
        step();
        step();
        reset = 1'b0;
        s = 1'b0;
        exp_q.push_back(V_WAIT);
        step();

        // s held: MOV imm then MVN back to back, fields changed mid-instruction
        cur_id = 400;
        s = 1'b1;
        opcode = 3'b110;
        op = 2'b10;
        exp_q.push_back(V_DEC);
        exp_q.push_back(V_WRIMM);
        exp_q.push_back(V_WAIT);
        exp_q.push_back(V_DEC);
        exp_q.push_back(V_GETB);
        exp_q.push_back(V_EXMOV);
        exp_q.push_back(V_WRREG);
        exp_q.push_back(V_WAIT);
        step();
        opcode = 3'b101;
        op = 2'b11;
        step();
        step();
        step();
        opcode = 3'b111;
        op = 2'b00;
        s = 1'b0;
        step();
        step();
        step();
        step();

        cur_id = 500;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL id%0d scoreboard-leftover got=%0d required=0", cur_id, exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
